// File: rtl/mult_pkg.sv
// Shared types and helpers for the shift-add multiplier.
// Latency: n/a (package only).
// Backpressure: n/a.
package mult_pkg;

  // Controller states. Busy and Done are decodes of COMPUTE and DONE.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Width of a counter able to hold 0..n-1; never less than one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/add_sub_n.sv
// Combinational N-bit adder/subtractor; callers supply pre-extended operands.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
//
// Ports:
//   a_i, b_i  N-bit operands
//   sub_i     1 = a_i - b_i, 0 = a_i + b_i
//   sum_o     N-bit result (wraps modulo 2^N)
module add_sub_n #(
  parameter int N = 9
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         sub_i,
  output logic [N-1:0] sum_o
);

  assign sum_o = sub_i ? (a_i - b_i) : (a_i + b_i);

endmodule

// File: rtl/shift_add_mult_n.sv
// Sequential shift-add multiplier, WIDTH bits, signed or unsigned, one bit per cycle.
// Latency: WIDTH+1 cycles from Run sampled in IDLE to Done.
// Backpressure: Run is ignored outside IDLE; DONE holds until Run is released.
//
// Ports:
//   Clk, Reset        clock, asynchronous active-high reset
//   Run               level start request (taken only in IDLE, wins over load)
//   ClearA_LoadB      in IDLE: B <= Switches, A <= 0, X <= 0
//   Signed_Mode       1 = two's complement, latched at start
//   Switches          operand S on start, operand B on load
//   Aval, Bval, X     product high half, low half, sign extension bit
//   Busy, Done        state decodes of COMPUTE and DONE
module shift_add_mult_n
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             ClearA_LoadB,
  input  logic             Signed_Mode,
  input  logic [WIDTH-1:0] Switches,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             X,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             x_q, x_d;
  logic             mode_q, mode_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] partial;
  logic [WIDTH:0]   op_a, op_b, sum;
  logic             do_sub;

  // Multiplier LSB selects whether S contributes this step.
  assign partial = b_q[0] ? s_q : '0;

  // One guard bit keeps the running sum exact: in signed mode the
  // final step may produce +2^(WIDTH-1) (e.g. -2^(W-1) * -2^(W-1)).
  assign op_a = mode_q ? {a_q[WIDTH-1], a_q} : {1'b0, a_q};
  assign op_b = mode_q ? {partial[WIDTH-1], partial} : {1'b0, partial};

  // The multiplier's top bit carries weight -2^(W-1) in two's complement,
  // so its partial product is subtracted.
  assign do_sub = mode_q && (cnt_q == LAST);

  add_sub_n #(.N(WIDTH + 1)) u_add_sub (
    .a_i   (op_a),
    .b_i   (op_b),
    .sub_i (do_sub),
    .sum_o (sum)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    x_d     = x_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (Run) begin
          s_d     = Switches;
          mode_d  = Signed_Mode;
          a_d     = '0;
          x_d     = 1'b0;
          cnt_d   = '0;
          state_d = COMPUTE;
        end else if (ClearA_LoadB) begin
          b_d = Switches;
          a_d = '0;
          x_d = 1'b0;
        end
      end
      COMPUTE: begin
        // Right shift of {sum, B}: sum MSB replicates into X (signed) and
        // the sum LSB drops into the top of B as the multiplier bit retires.
        x_d   = mode_q ? sum[WIDTH] : 1'b0;
        a_d   = sum[WIDTH:1];
        b_d   = {sum[0], b_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Hold until Run is released: one computation per press.
        if (!Run) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      x_q     <= 1'b0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      x_q     <= x_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Aval = a_q;
  assign Bval = b_q;
  assign X    = x_q;
  assign Busy = (state_q == COMPUTE);
  assign Done = (state_q == DONE);

endmodule

// File: doc/shift_add_mult_n.md
# shift_add_mult_n

Parametrised sequential shift-add multiplier: the next generation of the lab 8-bit multiplier, generalised to WIDTH bits with selectable signed/unsigned mode and an explicit Busy/Done handshake. Operand S comes from the switch bank; operand B is preloaded and replaced by the low product half. The block sits between the board I/O (switches, Run/ClearA_LoadB buttons) and the hex display drivers, which read Aval/Bval/X.

## Interface

Parameters:
- WIDTH, default 8, operand width; legal range 2..32.

Ports:
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high; clears all state.
- Run  in  1  level start request; a new computation starts only from IDLE.
- ClearA_LoadB  in  1  in IDLE: B <= Switches, A <= 0, X <= 0.
- Signed_Mode  in  1  1 = two's-complement operands, 0 = unsigned; latched at start.
- Switches  in  WIDTH  operand source (S for multiply, B for load).
- Aval  out  WIDTH  A register (product high half).
- Bval  out  WIDTH  B register (multiplier, then product low half).
- X  out  1  extension bit (product sign in signed mode, 0 in unsigned mode when done).
- Busy  out  1  high in COMPUTE.
- Done  out  1  high in DONE.

## Operation

- States: IDLE, COMPUTE, DONE. Reset -> IDLE; Aval, Bval, X, Busy, Done, counter, latched S and mode all 0.
- IDLE + Run=1: S_reg <= Switches, mode_reg <= Signed_Mode, A <= 0, X <= 0, cnt <= 0, -> COMPUTE. Run takes priority over ClearA_LoadB if both high.
- IDLE + ClearA_LoadB=1 (Run=0): B <= Switches, A <= 0, X <= 0; stay IDLE.
- COMPUTE, one bit per cycle:
  - Partial = B[0] ? S_reg : 0.
  - Signed: sum = sext(A) + sext(Partial), WIDTH+1 bits; on the final step (cnt = WIDTH-1) subtract instead of add. {X,A,B} <= arithmetic right shift of {sum,B}; X takes sum MSB.
  - Unsigned: sum = zext(A) + zext(Partial); carry shifts into A MSB; X <= 0.
  - cnt increments; after the step with cnt = WIDTH-1 -> DONE.
- DONE: registers hold. Run=0 -> IDLE; Run held high stays in DONE (one computation per press).
- ClearA_LoadB and Switches changes are ignored outside IDLE.
- Chained multiply: Run again without reload multiplies the new S by the previous low half in B.
- Reset mid-COMPUTE aborts immediately to IDLE with all registers 0.

## Timing

- Run sampled high in IDLE at edge k: Busy high after edge k+1 and through edge k+WIDTH. Done and the final product are valid after edge k+1+WIDTH; WIDTH+1 cycles total.
- Busy and Done are registered state decodes, never both high.
- Product {Aval,Bval} is 2*WIDTH bits; {X,Aval,Bval} is the sign-extended product in signed mode.
- Intermediate Aval/Bval change every COMPUTE cycle and are not meaningful until Done.
- Minimum re-start: Run must be low for at least one cycle in DONE; a new start is possible one cycle after DONE -> IDLE.

## Structure

- Package mult_pkg: state enum typedef (IDLE, COMPUTE, DONE) and a counter-width constant function clog2(WIDTH).
- One sub-module: add_sub_n (parameter WIDTH+1), combinational adder/subtractor with sub control and sign/zero extension handled by the caller. Its sum feeds the shift register.
- Top holds the FSM, counter, S_reg, mode_reg, and the {X,A,B} shift register.

## Test plan

All scenarios use WIDTH=8.
- Unsigned: load B=0x3B, S=0x07, Run -> after 9 cycles Done=1, Aval=0x01, Bval=0x9D, X=0.
- Signed negative: B=0x3B, S=0xF9 (-7) -> Aval=0xFE, Bval=0x63, X=1 (-413).
- Signed both negative / corner: B=0xC5, S=0xF9 -> Aval=0x01, Bval=0x9D, X=0. B=0x80, S=0x80 -> Aval=0x40, Bval=0x00, X=0.
- Chained: after the unsigned case, Run released and re-pressed with S=0x02 -> Aval=0x01, Bval=0x3A.
- Handshake: Run held high for 30 cycles -> exactly one computation, Done stays high, Busy high exactly 8 cycles. ClearA_LoadB pulsed during COMPUTE -> no effect.
- Reset at COMPUTE cycle 4 -> all outputs 0 immediately (asynchronous), state IDLE. A subsequent load/Run gives correct results.
